vga_text_term: RTL and testbench
================================

Name: vga_text_term

Overview:
Character-mode text terminal feeding the VGA timing stage. It holds a 70x30 character buffer and accepts ASCII bytes from the keyboard path over a valid/ready handshake. Cursor motion, backspace, newline, screen clear and scroll-up are handled by an internal state machine. On the read side it turns the VGA stage's cell coordinates (x, y) and pixel addresses (h_addr, v_addr) into a font-ROM address, and returns the selected glyph bit to the VGA stage as rom_data.

Parameters:
COLS, 70, characters per row (9-pixel cells)
ROWS, 30, character rows (16-pixel cells)
BLINK_CYCLES, 12500000, pclk cycles per cursor blink half-period (0.5 s at 25 MHz)

Ports:
pclk  input  1  25 MHz pixel clock; all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = asserted)
key_valid  input  1  key_ascii holds a byte to be consumed
key_ascii  input  8  ASCII byte
key_ready  output  1  block can accept a byte this cycle
x  input  7  character column from VGA stage (0..69)
y  input  5  character row from VGA stage (0..29)
h_addr  input  10  pixel column in active area (0..639)
v_addr  input  10  pixel row in active area (0..479)
font_addr  output  12  {char[7:0], v_addr[3:0]} to font ROM
font_row  input  12  glyph row from font ROM (combinational read); bits [8:0] used
rom_data  output  1  pixel on/off to VGA stage
cur_x  output  7  cursor column
cur_y  output  5  cursor row

Behaviour:
- Buffer: COLS*ROWS bytes, linear index = row*COLS + col. The VGA read port is combinational.
- FSM states: CLR_ALL, IDLE, SCROLL, CLR_ROW.
- key_ready = 1 only in IDLE. A byte is consumed on any pclk edge where key_valid & key_ready; back-to-back bytes are allowed (one per cycle).
- Reset asserted: state <= CLR_ALL, clear index <= 0, cur_x/cur_y <= 0, blink phase <= 0, blink counter <= 0. key_ready is 0 while in reset.
- CLR_ALL: writes 0x20 at one index per cycle, from 0 to COLS*ROWS-1 (2100 cycles), then goes to IDLE. rom_data is forced to 0 throughout CLR_ALL.
- Byte handling in IDLE (col = cur_x, row = cur_y):
  - 0x20..0x7E: buf[row][col] <= byte; col+1. If col+1 == COLS, then col <= 0 and a line advance occurs.
  - 0x0A: col <= 0, then a line advance.
  - 0x0D: col <= 0.
  - 0x08: if col > 0, col-1 and that cell <= 0x20. Else if row > 0, row-1, col <= COLS-1, and that cell <= 0x20. Else no effect.
  - 0x0C: cursor to (0,0), state <= CLR_ALL.
  - Any other byte is consumed with no effect.
- Line advance: if row < ROWS-1, then row+1. Otherwise row stays at ROWS-1 and state <= SCROLL.
- SCROLL: for i = 0..COLS*(ROWS-1)-1, one per cycle, buf[i] <= buf[i+COLS] (2030 cycles), then go to CLR_ROW.
- CLR_ROW: writes 0x20 over the last row, one cell per cycle (70 cycles), then goes to IDLE. The full scroll costs 2100 cycles with key_ready low.
- Display reads during SCROLL/CLR_ROW show partially moved data. This tearing is acceptable.
- Read path (combinational, zero latency, matching the VGA stage's same-cycle use of rom_data):
  - c = buf[y*COLS + x]
  - font_addr = {c, v_addr[3:0]}
  - pc = h_addr - 9*x (range 0..8; 10-bit arithmetic, truncated to 4 bits)
  - pix = font_row[pc]
- Cursor blink: a free-running counter counts 0..BLINK_CYCLES-1, then wraps and toggles the blink phase.
- rom_data = pix XOR (blink_phase & x==cur_x & y==cur_y), except 0 in CLR_ALL.
- x/y values outside 0..69 / 0..29 (blanking) are don't-care for rom_data.
- Reset asserted mid-SCROLL or mid-clear aborts the operation immediately. The whole buffer is then re-cleared.

Test Plan:
- Release reset, key_valid=1 held: key_ready stays 0 for exactly 2100 cycles, then rises; sampled buffer is all 0x20; rom_data=0 throughout clear.
- Send 'A','B',0x0D,'C': buf[0][0]=0x43, buf[0][1]=0x42; cur_x=1, cur_y=0. With x=0,y=0,v_addr[3:0]=5: font_addr=0x435.
- Send 70 'x' bytes: cur_x=0, cur_y=1, buf[0][69]=0x78. Then 0x08: cur_x=69, cur_y=0, buf[0][69]=0x20.
- Fill rows with row-tagged chars, place cursor at row 29, send 0x0A: key_ready low for 2100 cycles; afterwards row0 holds former row1 content, row 29 is all 0x20, cursor is (0,29).
- BLINK_CYCLES=4, cursor at (3,2), font_row=0: rom_data at x=3,y=2 toggles every 4 cycles; at x=4,y=2 it stays 0.
- Assert reset mid-SCROLL (cycle 500): key_ready drops asynchronously. After release, CLR_ALL runs the full 2100 cycles and the cursor is (0,0).

Source files
------------

// File: rtl/vga_text_term.sv
// Character-mode text terminal: a COLS x ROWS byte buffer written from a keyboard
// byte stream and read combinationally by the VGA stage to produce glyph pixels.
module vga_text_term #(
    parameter int COLS         = 70,
    parameter int ROWS         = 30,
    parameter int BLINK_CYCLES = 12500000
) (
    input  logic        pclk,
    input  logic        reset,
    input  logic        key_valid,
    input  logic [7:0]  key_ascii,
    output logic        key_ready,
    input  logic [6:0]  x,
    input  logic [4:0]  y,
    input  logic [9:0]  h_addr,
    input  logic [9:0]  v_addr,
    output logic [11:0] font_addr,
    input  logic [11:0] font_row,
    output logic        rom_data,
    output logic [6:0]  cur_x,
    output logic [4:0]  cur_y
);
    // state   | meaning
    // CLR_ALL | writing 0x20 over every cell, one per cycle
    // IDLE    | accepting key bytes
    // SCROLL  | moving each cell up one row, one per cycle
    // CLR_ROW | blanking the bottom row after a scroll
    localparam int CELLS = COLS * ROWS;
    localparam int AW    = $clog2(CELLS);
    localparam int BW    = $clog2(BLINK_CYCLES + 1);
    localparam logic [7:0] SPACE = 8'h20;

    typedef enum logic [1:0] {CLR_ALL, IDLE, SCROLL, CLR_ROW} state_t;

    state_t          state;
    logic [AW-1:0]   idx;
    logic [BW-1:0]   blink_cnt;
    logic            blink_phase;
    logic [7:0]      mem [0:CELLS-1];

    logic [AW-1:0]   cur_idx, rd_idx, src_idx, waddr;
    logic [7:0]      rd_char, src_char, wdata;
    logic            we, key_take, printable, advance, pix;
    logic [9:0]      pc_full;
    logic [15:0]     row_ext;
    logic            unused_bits;

    assign key_ready = (state == IDLE);
    assign key_take  = key_valid && (state == IDLE);
    assign printable = (key_ascii >= 8'h20) && (key_ascii <= 8'h7E);
    assign advance   = key_take && ((printable && cur_x == 7'(COLS - 1)) || key_ascii == 8'h0A);

    assign cur_idx  = AW'(cur_y) * AW'(COLS) + AW'(cur_x);
    assign rd_idx   = AW'(y) * AW'(COLS) + AW'(x);
    assign src_idx  = idx + AW'(COLS);
    // Blanking coordinates can index past the buffer; those reads are don't-care.
    assign rd_char  = (rd_idx < AW'(CELLS)) ? mem[rd_idx] : SPACE;
    assign src_char = (src_idx < AW'(CELLS)) ? mem[src_idx] : SPACE;

    always_comb begin
        we    = 1'b0;
        waddr = idx;
        wdata = SPACE;
        case (state)
            CLR_ALL, CLR_ROW: we = 1'b1;
            SCROLL: begin
                we    = 1'b1;
                wdata = src_char;
            end
            IDLE: begin
                if (key_take && printable) begin
                    we    = 1'b1;
                    waddr = cur_idx;
                    wdata = key_ascii;
                end else if (key_take && key_ascii == 8'h08 && cur_idx != '0) begin
                    // Previous cell in linear order covers both same-row and row-wrap cases.
                    we    = 1'b1;
                    waddr = cur_idx - AW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            state <= CLR_ALL;
            idx   <= '0;
            cur_x <= '0;
            cur_y <= '0;
        end else begin
            case (state)
                CLR_ALL, CLR_ROW: begin
                    if (idx == AW'(CELLS - 1)) begin
                        idx   <= '0;
                        state <= IDLE;
                    end else begin
                        idx <= idx + AW'(1);
                    end
                end
                SCROLL: begin
                    idx <= idx + AW'(1);
                    if (idx == AW'(CELLS - COLS - 1))
                        state <= CLR_ROW;
                end
                IDLE: begin
                    if (key_take) begin
                        if (printable) begin
                            cur_x <= (cur_x == 7'(COLS - 1)) ? 7'd0 : cur_x + 7'd1;
                        end else begin
                            case (key_ascii)
                                8'h0A, 8'h0D: cur_x <= '0;
                                8'h08: begin
                                    if (cur_x != '0) begin
                                        cur_x <= cur_x - 7'd1;
                                    end else if (cur_y != '0) begin
                                        cur_y <= cur_y - 5'd1;
                                        cur_x <= 7'(COLS - 1);
                                    end
                                end
                                8'h0C: begin
                                    cur_x <= '0;
                                    cur_y <= '0;
                                    idx   <= '0;
                                    state <= CLR_ALL;
                                end
                                default: ;
                            endcase
                        end
                        if (advance) begin
                            if (cur_y == 5'(ROWS - 1)) begin
                                idx   <= '0;
                                state <= SCROLL;
                            end else begin
                                cur_y <= cur_y + 5'd1;
                            end
                        end
                    end
                end
                default: state <= CLR_ALL;
            endcase
        end
    end

    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BW'(BLINK_CYCLES - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + BW'(1);
        end
    end

    assign font_addr   = {rd_char, v_addr[3:0]};
    assign pc_full     = h_addr - 10'(x) * 10'd9;
    assign row_ext     = {4'b0000, font_row};
    assign pix         = row_ext[pc_full[3:0]];
    assign unused_bits = ^{v_addr[9:4], pc_full[9:4]};

    assign rom_data = (state == CLR_ALL) ? 1'b0
                    : pix ^ (blink_phase && x == cur_x && y == cur_y);
endmodule

// File: tb/tb_vga_text_term.sv
// Bench for vga_text_term: directed scenarios plus random key traffic, checked
// every cycle against a cell-array model of the terminal.
module tb_vga_text_term;
    localparam int COLS  = 70;
    localparam int ROWS  = 30;
    localparam int CELLS = COLS * ROWS;
    localparam int BLINK = 4;

    logic        pclk = 1'b0;
    logic        reset;
    logic        key_valid;
    logic [7:0]  key_ascii;
    logic        key_ready;
    logic [6:0]  x;
    logic [4:0]  y;
    logic [9:0]  h_addr;
    logic [9:0]  v_addr;
    logic [11:0] font_addr;
    logic [11:0] font_row;
    logic        rom_data;
    logic [6:0]  cur_x;
    logic [4:0]  cur_y;

    vga_text_term #(.COLS(COLS), .ROWS(ROWS), .BLINK_CYCLES(BLINK)) dut (
        .pclk(pclk), .reset(reset), .key_valid(key_valid), .key_ascii(key_ascii),
        .key_ready(key_ready), .x(x), .y(y), .h_addr(h_addr), .v_addr(v_addr),
        .font_addr(font_addr), .font_row(font_row), .rom_data(rom_data),
        .cur_x(cur_x), .cur_y(cur_y)
    );

    always #5 pclk = ~pclk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mbuf [CELLS];
    int  m_x = 0, m_y = 0, m_busy = CELLS, m_kind = 1, m_cyc = 0;
    bit  rand_disp = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_x = 0; m_y = 0; m_busy = CELLS; m_kind = 1; m_cyc = 0;
        for (int i = 0; i < CELLS; i++) mbuf[i] = 8'h20;
    endtask

    task automatic model_advance();
        if (m_y < ROWS - 1) begin
            m_y++;
        end else begin
            for (int i = 0; i < CELLS - COLS; i++) mbuf[i] = mbuf[i + COLS];
            for (int i = CELLS - COLS; i < CELLS; i++) mbuf[i] = 8'h20;
            m_busy = CELLS; m_kind = 2;
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            mbuf[m_y * COLS + m_x] = b;
            m_x++;
            if (m_x == COLS) begin m_x = 0; model_advance(); end
        end else begin
            case (b)
                8'h0A: begin m_x = 0; model_advance(); end
                8'h0D: m_x = 0;
                8'h08: begin
                    if (m_x > 0) begin
                        m_x--; mbuf[m_y * COLS + m_x] = 8'h20;
                    end else if (m_y > 0) begin
                        m_y--; m_x = COLS - 1; mbuf[m_y * COLS + m_x] = 8'h20;
                    end
                end
                8'h0C: begin
                    m_x = 0; m_y = 0; m_busy = CELLS; m_kind = 1;
                    for (int i = 0; i < CELLS; i++) mbuf[i] = 8'h20;
                end
                default: ;
            endcase
        end
    endtask

    always @(posedge pclk) begin
        if (reset === 1'b1) begin
            m_cyc++;
            if (m_busy > 0) m_busy--;
            else if (key_valid) model_byte(key_ascii);
        end
    end

    always @(negedge pclk) begin
        if (rand_disp) begin
            x        = 7'($urandom_range(COLS - 1));
            y        = 5'($urandom_range(ROWS - 1));
            h_addr   = 10'(9 * int'(x) + int'($urandom_range(8)));
            v_addr   = 10'($urandom_range(479));
            font_row = 12'($urandom);
        end
    end

    always @(negedge pclk) begin
        int  pc;
        logic exp_rom;
        logic ready_exp;
        #2;
        ready_exp = (reset === 1'b1) && (m_busy == 0);
        check("key_ready", 32'(key_ready), 32'(ready_exp));
        check("cur_x", 32'(cur_x), m_x);
        check("cur_y", 32'(cur_y), m_y);
        pc = int'(h_addr) - 9 * int'(x);
        if (reset !== 1'b1 || (m_busy > 0 && m_kind == 1))
            exp_rom = 1'b0;
        else
            exp_rom = font_row[pc] ^ (((m_cyc / BLINK) % 2 == 1) && int'(x) == m_x && int'(y) == m_y);
        check("rom_data", 32'(rom_data), 32'(exp_rom));
        if (ready_exp)
            check("font_addr", 32'(font_addr), 32'({mbuf[int'(y) * COLS + int'(x)], v_addr[3:0]}));
    end

    task automatic wait_ready(output int n);
        n = 0;
        while (!key_ready && n < 5000) begin
            @(posedge pclk); #1;
            n++;
        end
        if (!key_ready) check("ready_timeout", 32'(key_ready), 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        key_valid = 1'b1;
        key_ascii = b;
        wait_ready(n);
        @(posedge pclk); #1;
        key_valid = 1'b0;
    endtask

    task automatic peek(input int cx, input int cy, output logic [7:0] c);
        rand_disp = 1'b0;
        x = 7'(cx); y = 5'(cy); h_addr = 10'(9 * cx); v_addr = '0;
        #1;
        c = font_addr[11:4];
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, cnt, r;
        logic [7:0] c, b;
        logic s [16];

        reset = 1'b0; key_valid = 1'b0; key_ascii = 8'h00;
        model_reset();
        repeat (3) @(posedge pclk);

        // Power-up clear with a byte already pending.
        key_valid = 1'b1; key_ascii = 8'h0D;
        @(negedge pclk); reset = 1'b1;
        wait_ready(n);
        check("clear_len", n, 2100);
        @(posedge pclk); #1; key_valid = 1'b0;
        peek(0, 0, c);   check("clear_cell_0_0", 32'(c), 32'h20);
        peek(69, 0, c);  check("clear_cell_69_0", 32'(c), 32'h20);
        peek(0, 29, c);  check("clear_cell_0_29", 32'(c), 32'h20);
        peek(69, 29, c); check("clear_cell_69_29", 32'(c), 32'h20);
        @(posedge pclk); #1;

        send_byte(8'h41); send_byte(8'h42); send_byte(8'h0D); send_byte(8'h43);
        check("abc_cur_x", 32'(cur_x), 32'd1);
        check("abc_cur_y", 32'(cur_y), 32'd0);
        rand_disp = 1'b0;
        x = 7'd0; y = 5'd0; h_addr = 10'd0; v_addr = 10'd5; #1;
        check("abc_font_addr0", 32'(font_addr), 32'h435);
        x = 7'd1; h_addr = 10'd9; #1;
        check("abc_font_addr1", 32'(font_addr), 32'h425);
        @(posedge pclk); #1; rand_disp = 1'b1;

        send_byte(8'h0C);
        for (int i = 0; i < COLS; i++) send_byte(8'h78);
        check("wrap_cur_x", 32'(cur_x), 32'd0);
        check("wrap_cur_y", 32'(cur_y), 32'd1);
        peek(69, 0, c); check("wrap_cell_69", 32'(c), 32'h78);
        @(posedge pclk); #1; rand_disp = 1'b1;
        send_byte(8'h08);
        check("bs_cur_x", 32'(cur_x), 32'd69);
        check("bs_cur_y", 32'(cur_y), 32'd0);
        peek(69, 0, c); check("bs_cell_69", 32'(c), 32'h20);
        peek(68, 0, c); check("bs_cell_68", 32'(c), 32'h78);
        @(posedge pclk); #1; rand_disp = 1'b1;

        // Row-tagged fill, then a newline on the bottom row scrolls.
        send_byte(8'h0C);
        for (int row = 0; row < ROWS - 1; row++)
            for (int col = 0; col < COLS; col++) send_byte(8'(8'h30 + row));
        for (int i = 0; i < 5; i++) send_byte(8'h4D);
        check("fill_cur_x", 32'(cur_x), 32'd5);
        check("fill_cur_y", 32'(cur_y), 32'd29);
        send_byte(8'h0A);
        wait_ready(n);
        check("scroll_len", n, 2100);
        check("scroll_cur_x", 32'(cur_x), 32'd0);
        check("scroll_cur_y", 32'(cur_y), 32'd29);
        peek(0, 0, c);   check("scroll_row0_a", 32'(c), 32'h31);
        peek(69, 0, c);  check("scroll_row0_b", 32'(c), 32'h31);
        peek(10, 27, c); check("scroll_row27", 32'(c), 32'h4C);
        peek(4, 28, c);  check("scroll_row28_tag", 32'(c), 32'h4D);
        peek(5, 28, c);  check("scroll_row28_sp", 32'(c), 32'h20);
        peek(0, 29, c);  check("scroll_row29_a", 32'(c), 32'h20);
        peek(69, 29, c); check("scroll_row29_b", 32'(c), 32'h20);
        @(posedge pclk); #1; rand_disp = 1'b1;

        // Cursor blink at (3,2) with a blank glyph.
        send_byte(8'h0C); send_byte(8'h0A); send_byte(8'h0A);
        for (int i = 0; i < 3; i++) send_byte(8'h71);
        rand_disp = 1'b0;
        font_row = '0; x = 7'd3; y = 5'd2; h_addr = 10'd27; v_addr = '0;
        for (int i = 0; i < 16; i++) begin @(posedge pclk); #1; s[i] = rom_data; end
        cnt = 0;
        for (int i = 0; i < 12; i++) if (s[i] != s[i + 4]) cnt++;
        check("blink_toggle", cnt, 12);
        x = 7'd4; h_addr = 10'd36;
        cnt = 0;
        for (int i = 0; i < 16; i++) begin @(posedge pclk); #1; if (rom_data) cnt++; end
        check("blink_off_cursor", cnt, 0);
        rand_disp = 1'b1;

        // Reset in the middle of a scroll.
        send_byte(8'h0C);
        for (int i = 0; i < 3; i++) send_byte(8'h6B);
        for (int i = 0; i < ROWS - 1; i++) send_byte(8'h0A);
        send_byte(8'h6D);
        send_byte(8'h0A);
        repeat (499) @(posedge pclk);
        #3;
        reset = 1'b0;
        model_reset();
        #1;
        check("reset_async_ready", 32'(key_ready), 32'd0);
        repeat (2) @(posedge pclk);
        @(negedge pclk); reset = 1'b1;
        wait_ready(n);
        check("reclear_len", n, 2100);
        check("reclear_cur_x", 32'(cur_x), 32'd0);
        check("reclear_cur_y", 32'(cur_y), 32'd0);
        peek(0, 29, c); check("reclear_cell_0_29", 32'(c), 32'h20);
        peek(0, 0, c);  check("reclear_cell_0_0", 32'(c), 32'h20);
        @(posedge pclk); #1; rand_disp = 1'b1;

        // Random key traffic.
        for (int k = 0; k < 400; k++) begin
            repeat ($urandom_range(2)) @(posedge pclk);
            #1;
            r = int'($urandom_range(99));
            if (r < 70)      b = 8'($urandom_range(8'h20, 8'h7E));
            else if (r < 80) b = 8'h0A;
            else if (r < 85) b = 8'h0D;
            else if (r < 93) b = 8'h08;
            else if (r < 94) b = 8'h0C;
            else if (r < 97) b = 8'($urandom_range(128, 255));
            else             b = 8'($urandom_range(0, 7));
            send_byte(b);
        end
        wait_ready(n);
        repeat (4) @(posedge pclk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
